// File: rtl/async_fifo_rd_port.sv
// async_fifo_rd_port: read-side controller of the async-compare FIFO (read pointer, empty sync, 2-entry output buffer)
// Define FIFO_RD_LEVEL_EN to expose the buffered-entry count on o_level.
module async_fifo_rd_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_rclk,
    input  logic                  dirclr_n,
    input  logic                  i_aempty_n,
    output logic [ADDR_WIDTH-1:0] o_rptr,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_ren,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
`ifdef FIFO_RD_LEVEL_EN
    output logic [1:0]            o_level,
`endif
    output logic                  o_rempty
);
    logic                  empty_set_n;
    logic                  rempty2;
    logic [ADDR_WIDTH-1:0] rbin;
    logic [ADDR_WIDTH-1:0] rbin_inc;
    logic                  rd_pend;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] tail;
    logic [1:0]            credit;
    logic                  pop;
    logic                  push;

    // Pointers meeting presets empty at once; deassertion takes two rclk edges.
    assign empty_set_n = dirclr_n & i_aempty_n;

    always_ff @(posedge i_rclk or negedge empty_set_n)
        if (!empty_set_n) {o_rempty, rempty2} <= 2'b11;
        else {o_rempty, rempty2} <= {rempty2, 1'b0};

    assign pop      = o_valid & i_ready;
    assign push     = rd_pend;
    assign credit   = buf_cnt + {1'b0, rd_pend};
    assign o_ren    = !o_rempty && (credit < 2'd2 || pop);
    assign rbin_inc = rbin + ADDR_WIDTH'(1);
    assign o_raddr  = rbin;
    assign o_valid  = buf_cnt != 2'd0;
`ifdef FIFO_RD_LEVEL_EN
    assign o_level  = buf_cnt;
`endif

    always_ff @(posedge i_rclk or negedge dirclr_n)
        if (!dirclr_n) begin
            rbin    <= '0;
            o_rptr  <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= o_ren;
            if (o_ren) begin
                rbin   <= rbin_inc;
                o_rptr <= rbin_inc ^ (rbin_inc >> 1);
            end
        end

    // o_data is the buffer head; tail only holds the second entry.
    always_ff @(posedge i_rclk or negedge dirclr_n)
        if (!dirclr_n) begin
            buf_cnt <= 2'd0;
            o_data  <= '0;
            tail    <= '0;
        end else begin
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
            if (push && (buf_cnt == 2'd0 || (pop && buf_cnt == 2'd1))) o_data <= i_rdata;
            else if (pop && buf_cnt == 2'd2) o_data <= tail;
            if (push && (buf_cnt == 2'd2 || (buf_cnt == 2'd1 && !pop))) tail <= i_rdata;
        end
endmodule

// File: tb/tb_async_fifo_rd_port.sv
// tb_async_fifo_rd_port: random + directed bench with a count-based FIFO model, comparator and 1-cycle RAM.
`timescale 1ns/1ps
module tb_async_fifo_rd_port;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int D  = 1 << AW;

    logic          clk = 0;
    logic          dirclr_n = 1;
    logic          i_ready = 0;
    logic          glitch = 0;
    logic          i_aempty_n;
    logic [AW-1:0] o_rptr, o_raddr;
    logic          o_ren, o_valid, o_rempty;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] o_data;
`ifdef FIFO_RD_LEVEL_EN
    logic [1:0]    o_level;
`endif
    logic [DW-1:0] mem [D];
    logic [DW-1:0] q [$];
    logic [3:0]    gt [16];
    int wcnt = 0, rcnt = 0, arrived = 0, popped = 0;
    logic rv = 0;
    int tests = 0, fails = 0;

    // Comparator model: empty exactly when every written word has been read.
    assign i_aempty_n = !glitch && (wcnt != rcnt);

    async_fifo_rd_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_rclk(clk), .dirclr_n(dirclr_n), .i_aempty_n(i_aempty_n),
        .o_rptr(o_rptr), .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(rdata),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
`ifdef FIFO_RD_LEVEL_EN
        .o_level(o_level),
`endif
        .o_rempty(o_rempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] gray(input int n);
        logic [AW-1:0] b;
        b = AW'(n);
        return 32'(b ^ (b >> 1));
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        mem[wcnt % D] = d;
        q.push_back(d);
        wcnt++;
    endtask

    task automatic rst();
        dirclr_n = 0;
        #1;
        wcnt = 0;
        q.delete();
        i_ready = 0;
        glitch = 0;
        tick(2);
        dirclr_n = 1;
    endtask

    task automatic drain(input string nm, input int target);
        int n;
        n = 0;
        i_ready = 1;
        while (popped != target && n < 200) begin
            tick();
            n++;
        end
        check({nm, "_popped"}, popped, target);
        check({nm, "_q_empty"}, q.size(), 0);
    endtask

    // RAM with registered read plus counters of reads issued, delivered and consumed.
    always @(posedge clk or negedge dirclr_n)
        if (!dirclr_n) begin
            rcnt <= 0; arrived <= 0; popped <= 0; rv <= 0;
        end else begin
            rv <= o_ren;
            if (o_ren) begin
                rcnt  <= rcnt + 1;
                rdata <= mem[o_raddr];
            end
            if (rv) arrived <= arrived + 1;
            if (o_valid && i_ready) popped <= popped + 1;
        end

    always @(negedge clk) if (dirclr_n) begin
        check("rptr", o_rptr, gray(rcnt));
        check("valid", o_valid, arrived > popped);
`ifdef FIFO_RD_LEVEL_EN
        check("level", o_level, arrived - popped);
`endif
        if (wcnt == rcnt) check("rempty_when_empty", o_rempty, 1);
        if (o_ren) begin
            check("raddr", o_raddr, rcnt % D);
            check("ren_nonempty", wcnt != rcnt, 1);
        end
        check("credit_le2", (rcnt + o_ren - popped - (o_valid && i_ready)) <= 2, 1);
        if (o_valid) begin
            if (q.size() == 0) check("data_unexpected", o_valid, 0);
            else begin
                check("data", o_data, q[0]);
                if (i_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nren, first, last, vcnt, n;
        logic cur;
        logic [DW-1:0] w0;
        gt = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        #2;
        rst();
        check("rst_rempty", o_rempty, 1);
        check("rst_valid", o_valid, 0);
        check("rst_rptr", o_rptr, 0);
        check("rst_ren", o_ren, 0);
        check("rst_data", o_data, 0);

        // single word
        i_ready = 1;
        wr(16'hA5A5);
        tick();
        check("t2_rempty_e1", o_rempty, 1);
        tick();
        check("t2_rempty_e2", o_rempty, 0);
        check("t2_ren", o_ren, 1);
        check("t2_raddr", o_raddr, 0);
        tick();
        check("t2_rempty_again", o_rempty, 1);
        check("t2_no_2nd_ren", o_ren, 0);
        check("t2_rptr", o_rptr, 1);
        check("t2_valid_early", o_valid, 0);
        tick();
        check("t2_valid", o_valid, 1);
        check("t2_data", o_data, 16'hA5A5);
        tick();
        check("t2_valid_gone", o_valid, 0);

        // 16 words with wrap
        rst();
        i_ready = 1;
        for (int i = 0; i < 16; i++) wr(DW'(i));
        k = 0; vcnt = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            cur = o_ren;
            tick();
            if (cur) begin
                if (k < 16) check("t3_rptr_seq", o_rptr, gt[k]);
                k++;
            end
            if (o_valid) begin
                vcnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check("t3_ren_count", k, 16);
        check("t3_valid_count", vcnt, 16);
        check("t3_no_gaps", last - first + 1, 16);
        check("t3_rptr_wrap", o_rptr, 0);

        // stall then drain
        rst();
        w0 = DW'($urandom);
        wr(w0);
        for (int i = 1; i < 8; i++) wr(DW'($urandom));
        nren = 0;
        for (int c = 0; c < 12; c++) begin
            nren += int'(o_ren);
            tick();
        end
        check("t4_ren_stalled", nren, 2);
        check("t4_valid", o_valid, 1);
        check("t4_head", o_data, w0);
`ifdef FIFO_RD_LEVEL_EN
        check("t4_level_full", o_level, 2);
`endif
        drain("t4", 8);
        check("t4_valid_end", o_valid, 0);
`ifdef FIFO_RD_LEVEL_EN
        check("t4_level_empty", o_level, 0);
`endif

        // glitch on almost-empty while data remains
        rst();
        i_ready = 1;
        for (int i = 0; i < 6; i++) wr(DW'(16'h100 + i));
        tick(4);
        glitch = 1;
        #1;
        check("t5_rempty_async", o_rempty, 1);
        check("t5_ren_blocked", o_ren, 0);
        #1;
        glitch = 0;
        tick();
        check("t5_rempty_hold", o_rempty, 1);
        drain("t5", 6);

        // randomized traffic
        rst();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) != 0 && wcnt - rcnt < D) wr(DW'($urandom));
            i_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 60) == 0) begin
                glitch = 1;
                #2;
                glitch = 0;
            end
            tick();
        end
        drain("rand", wcnt);

        // reset mid-stream
        rst();
        for (int i = 0; i < 5; i++) wr(DW'(16'h200 + i));
        tick(5);
        dirclr_n = 0;
        #1;
        check("t1_rempty", o_rempty, 1);
        check("t1_valid", o_valid, 0);
        check("t1_rptr", o_rptr, 0);
        check("t1_raddr", o_raddr, 0);
        check("t1_ren", o_ren, 0);
        wcnt = 0;
        q.delete();
        tick(2);
        dirclr_n = 1;
        i_ready = 1;
        wr(16'h1234);
        n = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n += int'(o_valid);
        end
        check("t1_no_stale_valid", n, 0);
        tick();
        check("t1_fresh_valid", o_valid, 1);
        check("t1_fresh_data", o_data, 16'h1234);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
